// File: rtl/tick_period_monitor.sv
// Measures edge-to-edge period of a slow tick in clk_in cycles,
// classifies it against EXPECTED+/-TOL and raises sticky error flags.
//
// Ports:
//   clk_in, rst_n              clock, async active-low reset
//   tick_in                    slow tick, asynchronous to clk_in
//   enable                     measurement enable (0 forces IDLE)
//   clear_err                  one-cycle clear of sticky flags
//   tick_pulse                 one-cycle pulse per synced rising edge
//   period / period_valid      last period and its update strobe
//   in_range                   last period within tolerance
//   too_fast/too_slow/timeout  sticky error flags
module tick_period_monitor #(
  parameter int CNT_W    = 27,
  parameter int EXPECTED = 40_000_000,
  parameter int TOL      = 400,
  parameter int TIMEOUT  = 80_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic             tick_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             too_fast,
  output logic             too_slow,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LO  = CNT_W'(EXPECTED - TOL);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(EXPECTED + TOL);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS
  } state_t;

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic tick_edge;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             inr_q, inr_d;
  logic             fast_q, fast_d;
  logic             slow_q, slow_d;
  logic             tmo_q, tmo_d;

  // Two sync flops, then a third stage holding the previous level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= tick_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= tick_edge;
    end
  end

  assign tick_edge = sync2_q & ~prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    inr_d    = inr_q;
    // Clear first so a same-cycle set below wins.
    fast_d   = fast_q & ~clear_err;
    slow_d   = slow_q & ~clear_err;
    tmo_d    = tmo_q & ~clear_err;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          cnt_d   = '0;
        end
        S_ARM: begin
          if (tick_edge) begin
            state_d = S_MEAS;
            cnt_d   = ONE;
          end
        end
        S_MEAS: begin
          if (tick_edge) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = ONE;
            inr_d    = (cnt_q >= LO) && (cnt_q <= HI);
            if (cnt_q < LO) fast_d = 1'b1;
            if (cnt_q > HI) slow_d = 1'b1;
          end else if (cnt_q == TMO) begin
            tmo_d   = 1'b1;
            inr_d   = 1'b0;
            state_d = S_ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      inr_q    <= 1'b0;
      fast_q   <= 1'b0;
      slow_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      inr_q    <= inr_d;
      fast_q   <= fast_d;
      slow_q   <= slow_d;
      tmo_q    <= tmo_d;
    end
  end

  assign tick_pulse   = pulse_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign in_range     = inr_q;
  assign too_fast     = fast_q;
  assign too_slow     = slow_q;
  assign timeout      = tmo_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Bench for tick_period_monitor: directed waveforms plus random
// periods, checked every cycle against an edge-timestamp model.
module tb_tick_period_monitor;

  localparam int CW  = 8;
  localparam int EXP = 100;
  localparam int TOL = 2;
  localparam int TMO = 200;
  localparam int LO  = EXP - TOL;
  localparam int HI  = EXP + TOL;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_in = 1'b0;
  logic          enable = 1'b0;
  logic          clear_err = 1'b0;
  logic          tick_pulse;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          in_range;
  logic          too_fast;
  logic          too_slow;
  logic          timeout;

  tick_period_monitor #(
    .CNT_W   (CW),
    .EXPECTED(EXP),
    .TOL     (TOL),
    .TIMEOUT (TMO)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .enable      (enable),
    .clear_err   (clear_err),
    .tick_pulse  (tick_pulse),
    .period      (period),
    .period_valid(period_valid),
    .in_range    (in_range),
    .too_fast    (too_fast),
    .too_slow    (too_slow),
    .timeout     (timeout)
  );

  always #5 clk_in = ~clk_in;

  int errs = 0;
  int checks = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: tick_in samples per posedge; a synced rise is acted on
  // two posedges after the first high sample.  Periods are the
  // difference of edge timestamps.
  bit [3:0] win;
  int       cyc;
  bit       en_prev;
  bit       have_ref;
  int       ref_c;
  bit       en_v;
  bit       auto_clr;
  int       e_period;
  bit       e_pulse, e_pv, e_inr, e_fast, e_slow, e_tmo;

  task automatic model_reset();
    win = '0;
    en_prev = 0;
    have_ref = 0;
    e_period = 0;
    {e_pulse, e_pv, e_inr, e_fast, e_slow, e_tmo} = '0;
  endtask

  task automatic check_all();
    check("tick_pulse", 32'(tick_pulse), 32'(e_pulse));
    check("period_valid", 32'(period_valid), 32'(e_pv));
    check("period", 32'(period), 32'(e_period));
    check("in_range", 32'(in_range), 32'(e_inr));
    check("too_fast", 32'(too_fast), 32'(e_fast));
    check("too_slow", 32'(too_slow), 32'(e_slow));
    check("timeout", 32'(timeout), 32'(e_tmo));
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(bit t, bit clr);
    bit r, c;
    int d;
    win = {win[2:0], t};
    r = win[2] & ~win[3];
    c = clr | (auto_clr & r);
    tick_in = t;
    enable = en_v;
    clear_err = c;
    cyc++;
    e_pulse = r;
    e_pv = 0;
    if (c) {e_fast, e_slow, e_tmo} = '0;
    if (!en_v || !en_prev) begin
      have_ref = 0;
    end else if (r) begin
      if (have_ref) begin
        d = cyc - ref_c;
        e_period = d;
        e_pv = 1;
        e_inr = (d >= LO) && (d <= HI);
        if (d < LO) e_fast = 1;
        if (d > HI) e_slow = 1;
      end
      have_ref = 1;
      ref_c = cyc;
    end else if (have_ref && (cyc - ref_c) == TMO) begin
      e_tmo = 1;
      e_inr = 0;
      have_ref = 0;
    end
    en_prev = en_v;
    @(posedge clk_in);
    #1;
    check_all();
    @(negedge clk_in);
    clear_err = 1'b0;
  endtask

  task automatic wave(int per, bit rclr);
    for (int i = 0; i < per; i++)
      step(i < per / 2, rclr && ($urandom_range(0, 40) == 0));
  endtask

  task automatic wave_gate(int per, int off_at, int off_len);
    for (int i = 0; i < per; i++) begin
      en_v = !(i >= off_at && i < off_at + off_len);
      step(i < per / 2, 1'b0);
    end
    en_v = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_in = 1'b0;
    clear_err = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    auto_clr = 0;
    en_v = 0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_all();
    rst_n = 1'b1;
    en_v = 1;

    repeat (5) wave(100, 0);

    wave(98, 0);
    wave(102, 0);
    wave(97, 0);
    wave(103, 0);
    repeat (2) wave(100, 0);
    step(1'b1, 1'b1);
    repeat (3) wave(100, 0);

    repeat (50) step(1'b1, 1'b0);
    repeat (250) step(1'b0, 1'b0);
    repeat (3) wave(100, 0);

    auto_clr = 1;
    wave(90, 0);
    auto_clr = 0;
    wave(100, 0);
    step(1'b1, 1'b1);
    repeat (2) wave(100, 0);

    wave_gate(100, 40, 30);
    repeat (3) wave(100, 0);

    for (int i = 0; i < 40; i++) step(i < 50, 1'b0);
    do_reset();
    for (int i = 40; i < 100; i++) step(i < 50, 1'b0);
    repeat (3) wave(100, 0);

    repeat (40) begin
      int per;
      per = $urandom_range(2, 230);
      if ($urandom_range(0, 7) == 0)
        wave_gate(per, $urandom_range(0, per - 1), $urandom_range(1, 20));
      else
        wave(per, 1);
    end
    wave(2, 0);
    wave(2, 0);
    repeat (2) wave(EXP, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
